// File: rtl/pc_fetch_gen_pkg.sv
// Shared types and constants for the fetch-address generator: FSM states,
// redirect priority levels and default reset/exception addresses.
package pc_fetch_gen_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } pc_state_e;

    // Larger value wins; PRIO_NONE means no redirect this cycle.
    typedef enum logic [2:0] {
        PRIO_NONE   = 3'd0,
        PRIO_BRANCH = 3'd1,
        PRIO_JUMP   = 3'd2,
        PRIO_JR     = 3'd3,
        PRIO_ERET   = 3'd4,
        PRIO_EXC    = 3'd5
    } redir_prio_e;

    localparam int          INST_BYTES   = 4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_0180;

    // A newer redirect replaces a buffered one unless the buffered one outranks it.
    function automatic logic prio_wins(input redir_prio_e new_p, input redir_prio_e old_p);
        return new_p >= old_p;
    endfunction

endpackage

// File: rtl/pc_fetch_gen_target_mux.sv
// Combinational redirect selection: picks the highest-priority redirect of the
// cycle and computes its target, plus the sequential successor of the fetch address.
module pc_fetch_gen_target_mux
    import pc_fetch_gen_pkg::*;
#(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] EXC_VEC = ADDR_W'(DEF_EXC_VEC)
) (
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [ADDR_W-1:0] i_if_addr,
    input  logic              i_exc,
    input  logic              i_eret,
    input  logic [ADDR_W-1:0] i_epc,
    input  logic              i_jr,
    input  logic [ADDR_W-1:0] i_jr_target,
    input  logic              i_jump,
    input  logic [25:0]       i_addr,
    input  logic              i_branch,
    input  logic [31:0]       i_offset,
    output logic              o_redir_valid,
    output redir_prio_e       o_redir_prio,
    output logic [ADDR_W-1:0] o_redir_target,
    output logic [ADDR_W-1:0] o_seq_addr
);

    logic [ADDR_W-1:0]  w_base;
    logic [ADDR_W+31:0] w_off_sext;
    logic [ADDR_W-1:0]  w_off_sh;
    logic [ADDR_W-1:0]  w_branch_target;
    logic [ADDR_W-1:0]  w_jump_target;
    logic               w_unused_off;

    // Targets are relative to the instruction currently held in decode.
    assign w_base          = i_pc + ADDR_W'(INST_BYTES);
    assign w_off_sext      = {{ADDR_W{i_offset[31]}}, i_offset};
    assign w_off_sh        = {w_off_sext[ADDR_W-3:0], 2'b00};
    assign w_unused_off    = ^w_off_sext[ADDR_W+31:ADDR_W-2];
    assign w_branch_target = w_base + w_off_sh;
    assign w_jump_target   = {w_base[ADDR_W-1:28], i_addr, 2'b00};
    assign o_seq_addr      = i_if_addr + ADDR_W'(INST_BYTES);

    always_comb begin
        o_redir_valid  = 1'b1;
        o_redir_prio   = PRIO_NONE;
        o_redir_target = o_seq_addr;
        if (i_exc) begin
            o_redir_prio   = PRIO_EXC;
            o_redir_target = EXC_VEC;
        end else if (i_eret) begin
            o_redir_prio   = PRIO_ERET;
            o_redir_target = i_epc;
        end else if (i_jr) begin
            o_redir_prio   = PRIO_JR;
            o_redir_target = i_jr_target;
        end else if (i_jump) begin
            o_redir_prio   = PRIO_JUMP;
            o_redir_target = w_jump_target;
        end else if (i_branch) begin
            o_redir_prio   = PRIO_BRANCH;
            o_redir_target = w_branch_target;
        end else begin
            o_redir_valid  = 1'b0;
        end
    end

endmodule

// File: rtl/pc_fetch_gen.sv
// Fetch-address generator: one outstanding req/ack fetch at a time, stall and
// prioritised redirects, a depth-1 pending-redirect buffer, and {pc, valid} to decode.
// Handshake: a fetch completes in a cycle where if_req_o && if_ack_i; while
// if_req_o && !if_ack_i the address is held stable.
module pc_fetch_gen
    import pc_fetch_gen_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
    parameter logic [ADDR_W-1:0] EXC_VEC  = ADDR_W'(DEF_EXC_VEC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              exc_i,
    input  logic              eret_i,
    input  logic [ADDR_W-1:0] epc_i,
    input  logic              jr_i,
    input  logic [ADDR_W-1:0] jr_target_i,
    input  logic              jump_i,
    input  logic [25:0]       addr_i,
    input  logic              branch_taken_i,
    input  logic [31:0]       offset_i,
    output logic              if_req_o,
    output logic [ADDR_W-1:0] if_addr_o,
    input  logic              if_ack_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              pc_valid_o,
    output pc_state_e         dbg_state_o
);

    pc_state_e         r_state;
    pc_state_e         w_state_nxt;
    logic [ADDR_W-1:0] r_if_addr,     w_if_addr_nxt;
    logic [ADDR_W-1:0] r_pc,          w_pc_nxt;
    logic              r_pc_valid,    w_pc_valid_nxt;
    logic              r_pend_valid,  w_pend_valid_nxt;
    logic [ADDR_W-1:0] r_pend_target, w_pend_target_nxt;
    redir_prio_e       r_pend_prio,   w_pend_prio_nxt;

    logic              w_redir_valid;
    redir_prio_e       w_redir_prio;
    logic [ADDR_W-1:0] w_redir_target;
    logic [ADDR_W-1:0] w_seq_addr;
    logic              w_capture;
    logic [ADDR_W-1:0] w_flush_target;
    redir_prio_e       w_flush_prio;

    pc_fetch_gen_target_mux #(
        .ADDR_W  (ADDR_W),
        .EXC_VEC (EXC_VEC)
    ) u_target_mux (
        .i_pc           (r_pc),
        .i_if_addr      (r_if_addr),
        .i_exc          (exc_i),
        .i_eret         (eret_i),
        .i_epc          (epc_i),
        .i_jr           (jr_i),
        .i_jr_target    (jr_target_i),
        .i_jump         (jump_i),
        .i_addr         (addr_i),
        .i_branch       (branch_taken_i),
        .i_offset       (offset_i),
        .o_redir_valid  (w_redir_valid),
        .o_redir_prio   (w_redir_prio),
        .o_redir_target (w_redir_target),
        .o_seq_addr     (w_seq_addr)
    );

    assign w_capture      = w_redir_valid && (!r_pend_valid || prio_wins(w_redir_prio, r_pend_prio));
    assign w_flush_target = w_redir_valid ? w_redir_target : r_pend_target;
    assign w_flush_prio   = w_redir_valid ? w_redir_prio   : r_pend_prio;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (!stall_i)            w_state_nxt = ST_REQ;
            ST_REQ:  if (if_ack_i && stall_i) w_state_nxt = ST_IDLE;
            default:                          w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_if_addr_nxt     = r_if_addr;
        w_pc_nxt          = r_pc;
        w_pc_valid_nxt    = 1'b0;
        w_pend_valid_nxt  = r_pend_valid;
        w_pend_target_nxt = r_pend_target;
        w_pend_prio_nxt   = r_pend_prio;
        case (r_state)
            ST_IDLE: begin
                if (!stall_i) begin
                    if (r_pend_valid)       w_if_addr_nxt = r_pend_target;
                    else if (w_redir_valid) w_if_addr_nxt = w_redir_target;
                    w_pend_valid_nxt = 1'b0;
                end else if (w_capture) begin
                    w_pend_valid_nxt  = 1'b1;
                    w_pend_target_nxt = w_redir_target;
                    w_pend_prio_nxt   = w_redir_prio;
                end
            end
            ST_REQ: begin
                if (!if_ack_i) begin
                    if (w_capture) begin
                        w_pend_valid_nxt  = 1'b1;
                        w_pend_target_nxt = w_redir_target;
                        w_pend_prio_nxt   = w_redir_prio;
                    end
                end else if (!r_pend_valid && !w_redir_valid) begin
                    w_pc_nxt       = r_if_addr;
                    w_pc_valid_nxt = 1'b1;
                    w_if_addr_nxt  = w_seq_addr;
                end else begin
                    // Returned instruction is on the wrong path: drop it and redirect.
                    w_pend_valid_nxt  = stall_i;
                    w_pend_target_nxt = w_flush_target;
                    w_pend_prio_nxt   = w_flush_prio;
                    if (!stall_i) w_if_addr_nxt = w_flush_target;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_if_addr     <= RESET_PC;
            r_pc          <= RESET_PC;
            r_pc_valid    <= 1'b0;
            r_pend_valid  <= 1'b0;
            r_pend_target <= RESET_PC;
            r_pend_prio   <= PRIO_NONE;
        end else begin
            r_if_addr     <= w_if_addr_nxt;
            r_pc          <= w_pc_nxt;
            r_pc_valid    <= w_pc_valid_nxt;
            r_pend_valid  <= w_pend_valid_nxt;
            r_pend_target <= w_pend_target_nxt;
            r_pend_prio   <= w_pend_prio_nxt;
        end
    end

    always_comb begin
        if_req_o    = (r_state == ST_REQ);
        if_addr_o   = r_if_addr;
        pc_o        = r_pc;
        pc_valid_o  = r_pc_valid;
        dbg_state_o = r_state;
    end

endmodule
